// File: rtl/mips_controller.sv
// mips_controller: multicycle MIPS control FSM (4-byte instruction fetch, LB/SB/R-type/BEQ/J/ADDI)
// Ports: clk, rst (async, active-low); op/funct/zero from the datapath;
//   memread/memwrite strobes, alusrca/memtoreg/iord/regwrite/regdst selects,
//   pcen, pcsource/alusrcb selects, irwrite byte enables, alucont, illop pulse, state (debug).
module mips_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic [1:0] alusrcb,
  output logic [3:0] irwrite,
  output logic [2:0] alucont,
  output logic       illop,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH1 = 4'd0, FETCH2 = 4'd1, FETCH3 = 4'd2, FETCH4 = 4'd3, DECODE = 4'd4,
    MEMADR = 4'd5, LBRD = 4'd6, LBWR = 4'd7, SBWR = 4'd8, RTYPEEX = 4'd9,
    RTYPEWR = 4'd10, BEQEX = 4'd11, JEX = 4'd12, ADDIEX = 4'd13, ADDIWR = 4'd14
  } state_e;
  localparam logic [5:0] OP_LB = 6'b100000, OP_SB = 6'b101000, OP_RT = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  logic [3:0] state_q, state_d;
  logic       run_q, run_d;
  logic       pcwrite, pcwritecond, funct_ok;
  logic [2:0] funct_alu;
  always_comb begin
    funct_ok = 1'b1;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default: begin
        funct_alu = 3'b010;
        funct_ok  = 1'b0;
      end
    endcase
  end
  always_comb begin
    run_d       = 1'b1;
    state_d     = state_q;
    memread     = 1'b0;
    memwrite    = 1'b0;
    alusrca     = 1'b0;
    memtoreg    = 1'b0;
    iord        = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    pcsource    = 2'b00;
    alusrcb     = 2'b00;
    irwrite     = 4'b0000;
    alucont     = 3'b010;
    illop       = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        irwrite = 4'b0001 << state_q[1:0];
        state_d = state_q + 4'd1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        state_d = (op == OP_LB || op == OP_SB) ? MEMADR :
                  (op == OP_RT)   ? RTYPEEX :
                  (op == OP_BEQ)  ? BEQEX   :
                  (op == OP_J)    ? JEX     :
                  (op == OP_ADDI) ? ADDIEX  : FETCH1;
        illop   = (state_d == FETCH1);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LB) ? LBRD : SBWR;
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = LBWR;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = FETCH1;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        state_d  = FETCH1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        alucont = funct_alu;
        illop   = ~funct_ok;
        state_d = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH1;
      end
      BEQEX: begin
        alusrca     = 1'b1;
        alucont     = 3'b110;
        pcsource    = 2'b01;
        pcwritecond = 1'b1;
        state_d     = FETCH1;
      end
      JEX: begin
        pcsource = 2'b10;
        pcwrite  = 1'b1;
        state_d  = FETCH1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWR;
      end
      ADDIWR: begin
        regwrite = 1'b1;
        state_d  = FETCH1;
      end
      default: state_d = FETCH1;
    endcase
    // FETCH1 is held for one extra edge after reset release
    if (!run_q) state_d = state_q;
    // reset overrides every strobe combinationally, not just via the state register
    if (!rst) begin
      memread     = 1'b0;
      memwrite    = 1'b0;
      alusrca     = 1'b0;
      memtoreg    = 1'b0;
      iord        = 1'b0;
      regwrite    = 1'b0;
      regdst      = 1'b0;
      pcsource    = 2'b00;
      alusrcb     = 2'b00;
      irwrite     = 4'b0000;
      alucont     = 3'b010;
      illop       = 1'b0;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
    end
    pcen = pcwrite | (pcwritecond & zero);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end
  assign state = state_q;
endmodule

// File: doc/mips_controller.md
MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous reset, active-low.
REQ-002 op  input  6  instr[31:26] from the datapath instruction register.
REQ-003 funct  input  6  instr[5:0] from the datapath instruction register.
REQ-004 zero  input  1  datapath ALU-result-is-zero flag.
REQ-005 memread, memwrite  output  1 each  memory read and write strobes.
REQ-006 alusrca, memtoreg, iord, regwrite, regdst  output  1 each  datapath mux selects and register-file write enable.
REQ-007 pcen  output  1  PC register load enable.
REQ-008 pcsource, alusrcb  output  2 each  PC and ALU-B mux selects.
REQ-009 irwrite  output  4  instruction-register byte load enables; bit0 loads instr[31:24], bit1 loads [23:16], bit2 loads [15:8], bit3 loads [7:0].
REQ-010 alucont  output  3  ALU operation code.
REQ-011 illop  output  1  one-cycle pulse on an undefined op or funct.
REQ-012 state  output  4  current FSM state, for debug and verification.

Function
REQ-013 The FSM SHALL be a Moore machine using a 4-bit state register: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14; code 15 SHALL go to FETCH1.
REQ-014 Transitions SHALL be FETCH1->FETCH2->FETCH3->FETCH4->DECODE, then from DECODE on op: 100000 (LB) or 101000 (SB) -> MEMADR; 000000 (R-type) -> RTYPEEX; 000100 (BEQ) -> BEQEX; 000010 (J) -> JEX; 001000 (ADDI) -> ADDIEX; any other op -> FETCH1 with illop=1 in DECODE.
REQ-015 The remaining transitions SHALL be MEMADR->LBRD if op=LB, else SBWR; LBRD->LBWR; RTYPEEX->RTYPEWR; ADDIEX->ADDIWR; and LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR each -> FETCH1.
REQ-016 FETCHn SHALL drive memread=1, iord=0, alusrca=0, alusrcb=01, alucont=010 (add), pcsource=00, PC write asserted, and irwrite one-hot: FETCH1=0001, FETCH2=0010, FETCH3=0100, FETCH4=1000.
REQ-017 DECODE SHALL drive alusrca=0, alusrcb=11, alucont=010, so the branch target is computed into the ALU output register.
REQ-018 MEMADR and ADDIEX SHALL drive alusrca=1, alusrcb=10, alucont=010.
REQ-019 LBRD SHALL drive memread=1, iord=1; SBWR SHALL drive memwrite=1, iord=1.
REQ-020 LBWR SHALL drive regwrite=1, memtoreg=1, regdst=0; ADDIWR SHALL drive regwrite=1, memtoreg=0, regdst=0; RTYPEWR SHALL drive regwrite=1, memtoreg=0, regdst=1.
REQ-021 RTYPEEX SHALL drive alusrca=1, alusrcb=00, with alucont decoded from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct SHALL give alucont=010 and illop=1, and RTYPEWR SHALL still occur.
REQ-022 BEQEX SHALL drive alusrca=1, alusrcb=00, alucont=110, pcsource=01, with conditional PC write asserted.
REQ-023 JEX SHALL drive pcsource=10 with PC write asserted.
REQ-024 pcen SHALL be combinational: pcen = PC write | (conditional PC write & zero), evaluated in the same cycle as zero.
REQ-025 All outputs not listed for a state SHALL be 0, except alucont, which defaults to 010.
REQ-026 Each instruction SHALL take: LB 8 cycles, SB 7, R-type 7, ADDI 7, BEQ 6, J 6.

Reset
REQ-027 While rst=0, state SHALL be FETCH1 asynchronously, and every output SHALL be forced to 0 except alucont=010 and state=0.
REQ-028 The first rising clk edge after rst deasserts SHALL find FETCH1 outputs active; the FSM SHALL leave FETCH1 on the second rising edge.
REQ-029 Asserting rst mid-instruction SHALL abort the instruction immediately; no regwrite, memwrite or pcen SHALL be asserted while rst=0.

Verification
REQ-030 Reset release, then op=100000 held: state sequence 0,1,2,3,4,5,6,7,0; memread=1 in states 6 and 0-3; regwrite=1 with memtoreg=1 only in state 7.
REQ-031 op=000000, funct=101010: RTYPEEX shows alucont=111; RTYPEWR shows regdst=1, regwrite=1; funct=111111 -> alucont=010 and a one-cycle illop pulse in state 9.
REQ-032 op=000100 in BEQEX: zero=1 -> pcen=1, pcsource=01; zero=0 -> pcen=0; next state 0 in both cases.
REQ-033 op=111111: DECODE pulses illop=1 and the next state is 0, with no regwrite or memwrite.
REQ-034 rst=0 asserted mid-SBWR: state goes to 0 asynchronously, memwrite drops to 0 the same cycle, and irwrite=0000 while rst=0.
REQ-035 Force state code 15 by backdoor: the next state is 0.
